// File: rtl/hsi_vector_mac_engine.sv
// Vector MAC engine: streams (a,b) component pairs and produces a saturated
// 16-bit dot product or a 3-component cross product.
module hsi_vector_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [1:0]               op_code_i,
  input  logic [15:0]              pixel_size_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic signed [DATA_W-1:0] s_a_i,
  input  logic signed [DATA_W-1:0] s_b_i,
  output logic signed [15:0]       result_o,
  output logic [47:0]              cross_o,
  output logic                     valid_result_o,
  output logic                     pixel_done_o,
  output logic                     busy_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int DIFF_W = 2 * DATA_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH1, FLUSH2, WRITE} state_t;

  state_t                    r_state;
  logic [1:0]                r_op;
  logic [15:0]               r_size;
  logic [15:0]               r_count;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_validResult;
  logic                      r_pixelDone;
  logic signed [15:0]        r_result;
  logic [47:0]               r_cross;
  logic signed [PROD_W-1:0]  r_prod;
  logic                      r_prodVld;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_a [0:3];
  logic signed [DATA_W-1:0]  r_b [0:3];
  logic signed [PROD_W-1:0]  r_p [0:5];
  logic signed [DIFF_W-1:0]  r_cx;
  logic signed [DIFF_W-1:0]  r_cy;
  logic signed [DIFF_W-1:0]  r_cz;

  logic        w_accept;
  logic        w_isCross;
  logic [15:0] w_target;
  logic        w_lastBeat;
  logic        w_degenerate;

  assign w_accept     = s_valid_i && r_ready;
  assign w_isCross    = (r_op == 2'b01);
  assign w_target     = w_isCross ? 16'd3 : r_size;
  assign w_lastBeat   = w_accept && (r_count == w_target - 16'd1);
  assign w_degenerate = op_code_i[1] || ((op_code_i == 2'b00) && (pixel_size_i == 16'd0));

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return 16'sh7fff;
    else if (v < SAT_MIN) return 16'sh8000;
    else                  return v[15:0];
  endfunction

  // Stage 2 of the dot pipeline runs in any state so the last product drains during FLUSH
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_op          <= '0;
      r_size        <= '0;
      r_count       <= '0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_validResult <= 1'b0;
      r_pixelDone   <= 1'b0;
      r_result      <= '0;
      r_cross       <= '0;
      r_prod        <= '0;
      r_prodVld     <= 1'b0;
      r_acc         <= '0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_cz          <= '0;
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      for (int i = 0; i < 6; i++) r_p[i] <= '0;
    end else begin
      r_prodVld   <= 1'b0;
      r_pixelDone <= 1'b0;
      if (r_prodVld) r_acc <= r_acc + ACC_W'(r_prod);

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op          <= op_code_i;
            r_size        <= pixel_size_i;
            r_count       <= '0;
            r_acc         <= '0;
            r_validResult <= 1'b0;
            r_cross       <= '0;
            r_busy        <= 1'b1;
            if (w_degenerate) begin
              r_state <= FLUSH1;
            end else begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_count <= r_count + 16'd1;
            if (w_isCross) begin
              r_a[r_count[1:0]] <= s_a_i;
              r_b[r_count[1:0]] <= s_b_i;
            end else begin
              r_prod    <= PROD_W'(s_a_i) * PROD_W'(s_b_i);
              r_prodVld <= 1'b1;
            end
            if (w_lastBeat) begin
              r_state <= FLUSH1;
              r_ready <= 1'b0;
            end
          end
        end
        FLUSH1: begin
          r_p[0]  <= PROD_W'(r_a[1]) * PROD_W'(r_b[2]);
          r_p[1]  <= PROD_W'(r_a[2]) * PROD_W'(r_b[1]);
          r_p[2]  <= PROD_W'(r_a[2]) * PROD_W'(r_b[0]);
          r_p[3]  <= PROD_W'(r_a[0]) * PROD_W'(r_b[2]);
          r_p[4]  <= PROD_W'(r_a[0]) * PROD_W'(r_b[1]);
          r_p[5]  <= PROD_W'(r_a[1]) * PROD_W'(r_b[0]);
          r_state <= FLUSH2;
        end
        FLUSH2: begin
          r_cx    <= DIFF_W'(r_p[0]) - DIFF_W'(r_p[1]);
          r_cy    <= DIFF_W'(r_p[2]) - DIFF_W'(r_p[3]);
          r_cz    <= DIFF_W'(r_p[4]) - DIFF_W'(r_p[5]);
          r_state <= WRITE;
        end
        WRITE: begin
          if (w_isCross) begin
            r_result <= sat16(ACC_W'(r_cz));
            r_cross  <= {sat16(ACC_W'(r_cz)), sat16(ACC_W'(r_cy)), sat16(ACC_W'(r_cx))};
          end else if (r_op == 2'b00) begin
            r_result <= sat16(r_acc);
          end else begin
            r_result <= '0;
          end
          r_validResult <= 1'b1;
          r_pixelDone   <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready_o      = r_ready;
  assign busy_o         = r_busy;
  assign valid_result_o = r_validResult;
  assign pixel_done_o   = r_pixelDone;
  assign result_o       = r_result;
  assign cross_o        = r_cross;

endmodule

// File: doc/hsi_vector_mac_engine.md
# hsi_vector_mac_engine

Compute engine driven by the HSI vector-core register wrapper. It consumes the wrapper's `start_o`, `op_code_o` and `pixel_size_o` outputs and returns `result`, `valid_result`, `pixel_done` and `busy`. Operand component pairs (a, b) stream in over a valid/ready handshake. The block computes either a dot product over `pixel_size` pairs or a 3-component cross product, saturated to 16-bit signed.

## Interface
- DATA_W, 8, signed operand component width
- ACC_W, 32, signed dot-product accumulator width; must be at least 2*DATA_W+16

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle start pulse
- op_code_i  in  2  00 = dot, 01 = cross, 10/11 = reserved
- pixel_size_i  in  16  number of component pairs for dot
- s_valid_i  in  1  operand beat valid
- s_ready_o  out  1  engine accepts a beat
- s_a_i  in  DATA_W  signed component of vector a
- s_b_i  in  DATA_W  signed component of vector b
- result_o  out  16  signed result: dot value, or c_z for cross
- cross_o  out  48  {c_z, c_y, c_x}, each 16-bit signed; zero after a dot
- valid_result_o  out  1  sticky result-valid
- pixel_done_o  out  1  one-cycle completion pulse
- busy_o  out  1  operation in progress

## Operation
- FSM states:
  - IDLE: s_ready_o=0.
  - RUN: s_ready_o=1.
  - FLUSH: 2 cycles, s_ready_o=0.
  - Write: returns to IDLE.
- IDLE + start_i:
  - Latch op_code and pixel_size.
  - Clear the beat counter, accumulator, valid_result_o and cross_o.
  - Go to RUN.
- Degenerate start (op 10/11, or dot with pixel_size=0): go straight to FLUSH; result 0, no beats consumed.
- start_i outside IDLE is ignored: latched values are unchanged and no restart occurs.
- RUN: a beat is accepted when s_valid_i && s_ready_o. Beat count is `pixel_size` for dot and exactly 3 for cross; pixel_size is ignored for cross.
- Dot:
  - Stage 1 registers the product a*b (2*DATA_W bits, signed).
  - Stage 2 sign-extends it and adds it into the ACC_W accumulator.
- Cross:
  - Beats 0..2 are stored as a0..a2 and b0..b2.
  - FLUSH cycle 1 registers the six products.
  - FLUSH cycle 2 registers the differences (17-bit): c_x=a1b2−a2b1, c_y=a2b0−a0b2, c_z=a0b1−a1b0.
- On acceptance of the last beat the FSM moves RUN→FLUSH on that same edge.
- Write stage:
  - Saturate to [−32768, 32767].
  - Update result_o (and cross_o for cross).
  - Set valid_result_o=1 and pulse pixel_done_o.
  - Drop busy_o.
  - Go to IDLE.
- valid_result_o stays high until the edge that accepts the next start.
- busy_o is registered and equals (state != IDLE).
- Async reset clears every register mid-operation. Partial results are discarded, and no pixel_done_o is emitted for the aborted operation.

## Timing
- Reset values: s_ready_o=0, result_o=0, cross_o=0, valid_result_o=0, pixel_done_o=0, busy_o=0.
- Start sampled at edge S: busy_o=1 and s_ready_o=1 from edge S (the first beat can be accepted at edge S+1). valid_result_o=0 from edge S.
- Last beat accepted at edge E: result_o/cross_o/valid_result_o/pixel_done_o update at edge E+3; busy_o falls at edge E+3.
- Degenerate start at edge S: outputs update at edge S+3.
- pixel_done_o is high for exactly one cycle per completed operation.
- Minimum start-to-start spacing is pixel_size+4 cycles for dot.
- Backpressure: s_valid_i gaps stall the count only. The pipeline still drains correctly, and latency is measured from the last accepted beat.
- s_a_i/s_b_i are sampled only on a handshake.

## Test plan
- Dot: pixel_size=4, a={1,2,3,4}, b={5,6,7,8}, back-to-back beats -> result_o=70, valid_result_o=1, one pixel_done_o pulse 3 edges after the last beat, cross_o=0.
- Saturation:
  - pixel_size=4, a=127, b=127 ×4 -> raw 64516, result_o=32767.
  - a=−128, b=127 ×4 -> raw −65024, result_o=−32768.
- Cross: a=(1,2,3), b=(4,5,6), pixel_size=9 -> exactly 3 beats consumed, cross_o={c_z=−3, c_y=6, c_x=−3}, result_o=−3.
- Backpressure and ignored start: dot of size 3 with s_valid_i low for 2 cycles between beats, and start_i pulsed mid-RUN -> ignored, correct sum, busy_o stays high throughout.
- Degenerate:
  - op=11 -> result_o=0 and valid_result_o at S+3, s_ready_o never high.
  - dot with pixel_size=0 -> same outcome.
- Reset mid-RUN after 2 of 4 beats -> all outputs 0 immediately. A following size-2 dot then returns the correct fresh result with no residue.
